// File: rtl/priority_decoder_pipe_if.sv
// Stream bundle for priority_decoder_pipe: index input and decoded-vector output.
// The master side drives the index and the output ready; the slave side is the decoder.
interface priority_decoder_pipe_if #(
   parameter int unsigned WIDTH = 16
) ();
   localparam int unsigned WIDTH_LOG = $clog2(WIDTH);

   logic                 enc_vld;
   logic [WIDTH_LOG-1:0] enc_idx;
   logic                 enc_rdy;
   logic                 dec_val;
   logic [WIDTH-1:0]     dec_oht;
   logic [WIDTH-1:0]     dec_thr;
   logic                 dec_err;
   logic                 dec_rdy;

   modport master (
      output enc_vld, enc_idx, dec_rdy,
      input  enc_rdy, dec_val, dec_oht, dec_thr, dec_err
   );

   modport slave (
      input  enc_vld, enc_idx, dec_rdy,
      output enc_rdy, dec_val, dec_oht, dec_thr, dec_err
   );
endinterface

// File: rtl/priority_decoder_pipe.sv
// Two-stage pipelined index decoder producing one-hot and thermometer vectors.
// Stage 1 splits the index into group/sub-index codes; stage 2 combines them.
module priority_decoder_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SPLIT = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   priority_decoder_pipe_if.slave bus
);
   localparam int unsigned WIDTH_LOG = $clog2(WIDTH);
   localparam int unsigned SPLIT_LOG = $clog2(SPLIT);
   localparam int unsigned GROUPS    = WIDTH / SPLIT;
   localparam int unsigned HI_W      = WIDTH_LOG - SPLIT_LOG;

   logic [SPLIT_LOG-1:0] lo;
   logic [HI_W-1:0]      hi;

   logic [GROUPS-1:0] hoh_d, htr_d, s1_hoh_q, s1_htr_q;
   logic [SPLIT-1:0]  loh_d, ltr_d, s1_loh_q, s1_ltr_q;
   logic              err_d, s1_err_q;
   logic              s1_val_d, s1_val_q;

   logic [WIDTH-1:0] oht_d, thr_d, oht_q, thr_q;
   logic             err_q;
   logic             val_d, val_q;

   logic s2_adv, s1_adv, enc_rdy, in_xfer;

   assign s2_adv  = !val_q || bus.dec_rdy;
   assign s1_adv  = s1_val_q && s2_adv;
   assign enc_rdy = !s1_val_q || s2_adv;
   assign in_xfer = bus.enc_vld && enc_rdy;

   assign s1_val_d = in_xfer || (s1_val_q && !s2_adv);
   assign val_d    = s1_adv || (val_q && !bus.dec_rdy);

   assign lo = bus.enc_idx[SPLIT_LOG-1:0];
   assign hi = bus.enc_idx[WIDTH_LOG-1:SPLIT_LOG];

   // Out-of-range indices land in a group number >= GROUPS, so both group codes come out zero.
   always_comb begin
      hoh_d = '0;
      htr_d = '0;
      loh_d = '0;
      ltr_d = '0;
      for (int unsigned g = 0; g < GROUPS; g++) begin
         hoh_d[g] = (HI_W'(g) == hi);
         htr_d[g] = (HI_W'(g) >= hi);
      end
      for (int unsigned s = 0; s < SPLIT; s++) begin
         loh_d[s] = (SPLIT_LOG'(s) == lo);
         ltr_d[s] = (SPLIT_LOG'(s) >= lo);
      end
      err_d = ({1'b0, bus.enc_idx} >= (WIDTH_LOG + 1)'(WIDTH));
   end

   always_comb begin
      oht_d = '0;
      thr_d = '0;
      for (int unsigned g = 0; g < GROUPS; g++) begin
         for (int unsigned s = 0; s < SPLIT; s++) begin
            oht_d[g*SPLIT+s] = s1_hoh_q[g] & s1_loh_q[s];
            thr_d[g*SPLIT+s] = (s1_htr_q[g] & ~s1_hoh_q[g]) | (s1_hoh_q[g] & s1_ltr_q[s]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_val_q <= 1'b0;
         s1_hoh_q <= '0;
         s1_htr_q <= '0;
         s1_loh_q <= '0;
         s1_ltr_q <= '0;
         s1_err_q <= 1'b0;
         val_q    <= 1'b0;
         oht_q    <= '0;
         thr_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         s1_val_q <= s1_val_d;
         val_q    <= val_d;
         if (in_xfer) begin
            s1_hoh_q <= hoh_d;
            s1_htr_q <= htr_d;
            s1_loh_q <= loh_d;
            s1_ltr_q <= ltr_d;
            s1_err_q <= err_d;
         end
         if (s1_adv) begin
            oht_q <= oht_d;
            thr_q <= thr_d;
            err_q <= s1_err_q;
         end
      end
   end

   assign bus.enc_rdy = enc_rdy;
   assign bus.dec_val = val_q;
   assign bus.dec_oht = oht_q;
   assign bus.dec_thr = thr_q;
   assign bus.dec_err = err_q;
endmodule

// File: tb/tb_priority_decoder_pipe.sv
// Randomised and directed bench for priority_decoder_pipe against an arithmetic index model.
module tb_priority_decoder_pipe;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   priority_decoder_pipe_if #(.WIDTH(16)) bus16 ();
   priority_decoder_pipe_if #(.WIDTH(12)) bus12 ();

   priority_decoder_pipe #(.WIDTH(16), .SPLIT(4)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   priority_decoder_pipe #(.WIDTH(12), .SPLIT(4)) u_dut12 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus12)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_q[$];
   int          stamp_q[$];
   int          cyc_n    = 0;
   int          n_out    = 0;
   bit          chk_lat  = 1'b0;
   bit          hold_pend = 1'b0;
   logic [63:0] held;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] m_oht(input int i, input int w);
      if (i >= w) return 64'd0;
      return 64'd1 << i;
   endfunction

   function automatic logic [63:0] m_thr(input int i, input int w);
      if (i >= w) return 64'd0;
      return ((64'd1 << w) - 64'd1) & ~((64'd1 << i) - 64'd1);
   endfunction

   // Lowest set bit, i.e. what a priority encoder would recover from either vector.
   function automatic int lowest_set(input logic [63:0] v);
      for (int i = 0; i < 64; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic cyc(input logic vld, input int idx, input logic rdy, output bit acc);
      logic [63:0] snap;
      int          e;
      int          st;
      bus16.enc_vld = vld;
      bus16.enc_idx = 4'(idx);
      bus16.dec_rdy = rdy;
      #1;
      snap = {30'b0, bus16.dec_val, bus16.dec_err, bus16.dec_thr, bus16.dec_oht};
      if (hold_pend) check_eq("hold_stable", snap, held);
      if (bus16.dec_val && rdy) begin
         n_out++;
         check_eq("out_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            st = stamp_q.pop_front();
            check_eq("oht", 64'(bus16.dec_oht), m_oht(e, 16));
            check_eq("thr", 64'(bus16.dec_thr), m_thr(e, 16));
            check_eq("err", 64'(bus16.dec_err), 64'(e >= 16));
            check_eq("rt_oht", 64'(lowest_set(64'(bus16.dec_oht))), 64'(e));
            check_eq("rt_thr", 64'(lowest_set(64'(bus16.dec_thr))), 64'(e));
            if (chk_lat) check_eq("latency", 64'(cyc_n - st), 64'd2);
         end
      end
      hold_pend = bus16.dec_val && !rdy;
      held      = snap;
      acc       = vld && bus16.enc_rdy;
      if (acc) begin
         exp_q.push_back(idx);
         stamp_q.push_back(cyc_n);
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   initial begin
      bit acc;
      int k;
      int n0;
      int vd;
      int rd;
      int vals12[3];
      vals12 = '{11, 12, 15};

      rst_n = 1'b0;
      bus16.enc_vld = 1'b0; bus16.enc_idx = '0; bus16.dec_rdy = 1'b0;
      bus12.enc_vld = 1'b0; bus12.enc_idx = '0; bus12.dec_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_val", 64'(bus16.dec_val), 64'd0);
      check_eq("rst_rdy", 64'(bus16.enc_rdy), 64'd1);
      check_eq("rst_oht", 64'(bus16.dec_oht), 64'd0);
      check_eq("rst_thr", 64'(bus16.dec_thr), 64'd0);

      // Back-to-back sweep of every index.
      chk_lat = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, i, 1'b1, acc);
         check_eq("sweep_rdy", 64'(acc), 64'd1);
      end
      repeat (3) cyc(1'b0, 0, 1'b1, acc);
      check_eq("sweep_drained", 64'(exp_q.size()), 64'd0);
      check_eq("sweep_count", 64'(n_out), 64'd16);

      // Back-pressure: two entries fill the pipe, then input stalls.
      chk_lat = 1'b0;
      n0 = n_out;
      cyc(1'b1, 3, 1'b0, acc);  check_eq("bp_acc3", 64'(acc), 64'd1);
      cyc(1'b1, 7, 1'b0, acc);  check_eq("bp_acc7", 64'(acc), 64'd1);
      cyc(1'b1, 9, 1'b0, acc);  check_eq("bp_full0", 64'(acc), 64'd0);
      cyc(1'b1, 9, 1'b0, acc);  check_eq("bp_full1", 64'(acc), 64'd0);
      cyc(1'b1, 9, 1'b1, acc);  check_eq("bp_resume", 64'(acc), 64'd1);
      cyc(1'b1, 12, 1'b1, acc); check_eq("bp_acc12", 64'(acc), 64'd1);
      repeat (4) cyc(1'b0, 0, 1'b1, acc);
      check_eq("bp_drained", 64'(exp_q.size()), 64'd0);
      check_eq("bp_count", 64'(n_out - n0), 64'd4);

      // Reset while two entries are stalled.
      cyc(1'b1, 1, 1'b0, acc);
      cyc(1'b1, 2, 1'b0, acc);
      rst_n = 1'b0;
      bus16.enc_vld = 1'b0;
      bus16.dec_rdy = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check_eq("mrst_val", 64'(bus16.dec_val), 64'd0);
      check_eq("mrst_oht", 64'(bus16.dec_oht), 64'd0);
      check_eq("mrst_thr", 64'(bus16.dec_thr), 64'd0);
      check_eq("mrst_err", 64'(bus16.dec_err), 64'd0);
      check_eq("mrst_rdy", 64'(bus16.enc_rdy), 64'd1);
      exp_q.delete();
      stamp_q.delete();
      hold_pend = 1'b0;
      chk_lat = 1'b1;
      n0 = n_out;
      cyc(1'b1, 6, 1'b1, acc);
      repeat (3) cyc(1'b0, 0, 1'b1, acc);
      check_eq("mrst_count", 64'(n_out - n0), 64'd1);
      chk_lat = 1'b0;

      // Out-of-range indices on the 12-wide instance.
      k = 0;
      for (int c = 0; c < 7; c++) begin
         bus12.enc_vld = (c < 3);
         bus12.enc_idx = (c < 3) ? 4'(vals12[c]) : 4'd0;
         #1;
         if (c < 3) check_eq("w12_rdy", 64'(bus12.enc_rdy), 64'd1);
         if (bus12.dec_val && k < 3) begin
            check_eq("w12_lat", 64'(c - k), 64'd2);
            check_eq("w12_oht", 64'(bus12.dec_oht), m_oht(vals12[k], 12));
            check_eq("w12_thr", 64'(bus12.dec_thr), m_thr(vals12[k], 12));
            check_eq("w12_err", 64'(bus12.dec_err), 64'(vals12[k] >= 12));
            k++;
         end
         @(posedge clk);
         #1;
      end
      check_eq("w12_count", 64'(k), 64'd3);

      // Random duty cycles on both handshakes.
      for (int b = 0; b < 10; b++) begin
         vd = int'($urandom_range(30, 90));
         rd = int'($urandom_range(30, 90));
         repeat (1000) begin
            cyc(int'($urandom_range(0, 99)) < vd, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 99)) < rd, acc);
         end
      end
      repeat (4) cyc(1'b0, 0, 1'b1, acc);
      check_eq("rand_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
